// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory for the fetch stage: a loader streams
// program words in over valid/ready, then fetches read them back one cycle later.
module imem_loadable #(
  parameter int                DATA_W   = 18,
  parameter int                ADDR_W   = 18,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_full,
  output logic [CNT_W-1:0]  word_count,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_fault,
  output logic              running
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_fault;
  logic              load_fire;
  logic              fetch_fire;
  logic              enter_load;

  assign fetch_idx   = fetch_addr[ADDR_W-1:2];
  // Full-width unsigned compare against the fill level: indices never wrap.
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) ||
                       ({{CNT_W{1'b0}}, fetch_idx} >= {{IDX_W{1'b0}}, word_count});

  assign load_ready  = (state == ST_LOAD) && (word_count < CNT_W'(DEPTH));
  assign load_full   = (word_count == CNT_W'(DEPTH));
  assign fetch_ready = (state == ST_RUN) && !load_en && (!rd_valid || rd_ready);
  assign running     = (state == ST_RUN);

  assign load_fire   = load_valid && load_ready;
  assign fetch_fire  = fetch_valid && fetch_ready;
  assign enter_load  = (state != ST_LOAD) && load_en;

  // NOTE: the program store has no reset; stale words are hidden by word_count,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[word_count[MEM_AW-1:0]] <= load_data;
    end
  end

  // NOTE: every sequential assignment is non-blocking so all registers see the
  // pre-edge values of state and word_count, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      word_count <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= NOP_WORD;
      rd_fault   <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY, ST_RUN: begin
          if (load_en) begin
            state      <= ST_LOAD;
            word_count <= '0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            word_count <= word_count + CNT_W'(1);
          end
          // A word accepted on the same edge load_en falls still counts.
          if (!load_en) begin
            state <= ((word_count != '0) || load_fire) ? ST_RUN : ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase

      if (enter_load) begin
        rd_valid <= 1'b0;
      end else if (fetch_fire) begin
        rd_valid <= 1'b1;
        rd_data  <= fetch_fault ? NOP_WORD : mem[fetch_idx[MEM_AW-1:0]];
        rd_fault <= fetch_fault;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, run-time loadable instruction memory for the vector processor's fetch stage. Replaces the fixed, hard-wired program store. A loader streams program words in through a valid/ready port, then the fetch stage reads them with a one-cycle registered read and stall support. Reads that are out of range or misaligned return a defined NOP word and raise a fault flag.

## Interface
Parameters:
- DATA_W, 18, instruction word width
- ADDR_W, 18, fetch byte-address width
- DEPTH, 128, number of instruction words; need not be a power of two
- NOP_WORD, 18'b0, value returned on any faulting read
- CNT_W, $clog2(DEPTH+1), width of the fill counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  level; high requests and holds load mode
- load_valid  in  1  load word present
- load_data  in  DATA_W  program word
- load_ready  out  1  memory accepts a load word this cycle
- load_full  out  1  fill counter equals DEPTH
- word_count  out  CNT_W  number of words currently loaded
- fetch_valid  in  1  fetch request
- fetch_addr  in  ADDR_W  byte address; word index = fetch_addr[ADDR_W-1:2]
- fetch_ready  out  1  fetch accepted this cycle
- rd_valid  out  1  rd_data/rd_fault valid
- rd_ready  in  1  consumer takes the read result
- rd_data  out  DATA_W  instruction word
- rd_fault  out  1  result is NOP_WORD because of a fault
- running  out  1  state is RUN

## Operation
- States:
  - EMPTY: the reset state.
  - LOAD: words are being written.
  - RUN: fetches are being served.
- Transitions:
  - EMPTY or RUN -> LOAD when load_en=1.
  - LOAD -> RUN when load_en=0 and word_count>0.
  - LOAD -> EMPTY when load_en=0 and word_count=0.
- Entering LOAD:
  - word_count clears to 0.
  - Any pending read result is dropped (rd_valid=0 next cycle).
- Load handshake:
  - load_ready = (state==LOAD) && (word_count<DEPTH).
  - On load_valid && load_ready, load_data is written at index word_count, and word_count increments by 1.
  - When full, load_ready=0 and load_full=1. Extra words are not accepted. The block stays in LOAD until load_en=0.
- Fetch handshake:
  - fetch_ready = (state==RUN) && !load_en && (!rd_valid || rd_ready).
  - A fetch is accepted on fetch_valid && fetch_ready.
- Fault rules for an accepted fetch:
  - If fetch_addr[1:0]!=0, or the word index >= word_count, then rd_data=NOP_WORD and rd_fault=1.
  - Otherwise rd_data = mem[index] and rd_fault=0.
  - The index comparison is unsigned and uses the full ADDR_W-2 bit index. There is no wrap-around: an index at or beyond DEPTH always faults.
- Output register:
  - rd_valid/rd_data/rd_fault hold while rd_valid && !rd_ready.
  - rd_valid clears when the result is consumed with no new fetch accepted that cycle.
- Memory array contents are not cleared by rst. Data is visible only below word_count.

## Timing
- Reset values (cycle after rst=1):
  - State EMPTY, so running=0.
  - word_count=0, load_full=0, load_ready=0, fetch_ready=0.
  - rd_valid=0, rd_fault=0, rd_data=NOP_WORD.
- rst has priority over every other input. Reset mid-load or mid-fetch discards all progress.
- Read latency: a fetch accepted in cycle N produces rd_valid=1 in cycle N+1.
- Throughput:
  - One fetch per cycle while rd_ready=1.
  - One load word per cycle while load_valid=1.
- A write at index k is readable by a fetch accepted in any cycle after the write cycle. Read-during-write cannot occur, because fetch is blocked in LOAD.
- load_en=1 while in RUN:
  - fetch_ready drops in the same cycle (combinational).
  - The state becomes LOAD at the next edge, and rd_valid clears at that edge.
- LOAD -> RUN takes effect at the edge after load_en falls. The first fetch can be accepted in that RUN cycle.
- Simultaneous load_en=0 and load_valid=1 in LOAD: the word is written if load_ready=1, and the state moves to RUN at the same edge. The new count includes that word.

## Test plan
- Reset then idle:
  - Check every output holds its reset value for 5 cycles.
  - fetch_valid=1 at address 0 is never accepted in EMPTY.
- Load 4 words (0x00001, 0x0ABCD, 0x3FFFF, 0x12345), then drop load_en. Fetch addresses 0, 4, 8, 12:
  - Required: rd_data in that order, rd_fault=0, one cycle after each accept.
  - Required: word_count=4.
- Fault cases with 4 words loaded:
  - Fetch address 16 -> NOP_WORD, rd_fault=1.
  - Fetch address 6 -> NOP_WORD, rd_fault=1.
  - Fetch address 4*DEPTH -> NOP_WORD, rd_fault=1.
- Backpressure:
  - Accept fetch at address 4, then hold rd_ready=0 for 3 cycles.
  - Required: rd_data stays 0x0ABCD and fetch_ready=0 throughout.
  - Release: the next fetch is accepted in the same cycle rd_ready=1.
- Fill to DEPTH with load_valid held high, plus 2 extra words:
  - Required: load_full=1 and load_ready=0, and word_count=DEPTH.
  - Required: the last word reads back from address 4*(DEPTH-1).
- Reload and reset:
  - Reload in RUN with a read pending: the pending read is dropped, and word_count returns to 0 at the next edge.
  - rst asserted after 2 load words: EMPTY, word_count=0.
